// File: rtl/ddr_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ddr_test_sequencer
// Purpose  : Traffic generator / checker for a DDR3 controller user (app_*)
//            interface. After calibration it writes an address-derived
//            pattern over a region, reads it back and checks it in order,
//            then repeats (LOOP=1) or stops in DONE (LOOP=0).
// Ports    : clk_x1, rst_n (sync, active-low)     - user clock / reset
//            init_calib_complete                  - controller calibrated
//            app_rdy / app_wdf_rdy                - command / data accept
//            app_rd_data_valid / app_rd_data      - read return
//            app_en, app_cmd, app_addr            - command channel
//            app_wdf_wren, app_wdf_end, app_wdf_data - write data channel
//            init_calib_complete_d, error, error_cnt, pass_cnt,
//            test_done, led                       - status
//            timeout                              - only with the macro
// Options  : DDR_TEST_TIMEOUT_EN adds a 32-bit inactivity watchdog with
//            limit TIMEOUT_CYC and a sticky 'timeout' output.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_test_sequencer #(
    parameter int          ADDR_WIDTH  = 29,
    parameter int          DATA_WIDTH  = 256,
    parameter int unsigned START_ADDR  = 0,
    parameter int unsigned ADDR_STEP   = 8,
    parameter int unsigned TEST_LEN    = 1024,
    parameter int          LOOP        = 1,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                  clk_x1,
    input  logic                  rst_n,
    input  logic                  init_calib_complete,
    input  logic                  app_rdy,
    input  logic                  app_wdf_rdy,
    input  logic                  app_rd_data_valid,
    input  logic [DATA_WIDTH-1:0] app_rd_data,
    output logic                  app_en,
    output logic [2:0]            app_cmd,
    output logic [ADDR_WIDTH-1:0] app_addr,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    output logic [DATA_WIDTH-1:0] app_wdf_data,
    output logic                  init_calib_complete_d,
    output logic                  error,
    output logic [15:0]           error_cnt,
    output logic [15:0]           pass_cnt,
    output logic                  test_done,
`ifdef DDR_TEST_TIMEOUT_EN
    output logic                  timeout,
`endif
    output logic                  led
);

    localparam int                  c_LANES = DATA_WIDTH / 32;
    localparam int                  c_CNT_W = 25;   // holds TEST_LEN up to 2^24
    localparam logic [c_CNT_W-1:0]  c_LEN   = c_CNT_W'(TEST_LEN);
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(TEST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] c_START = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_STEP  = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [2:0]          c_CMD_WR = 3'b000;
    localparam logic [2:0]          c_CMD_RD = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_READ    = 3'd2,
        S_WAIT_RD = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t r_state, w_state_next;

    logic                  r_app_en, r_app_wdf_wren, r_init_d, r_error, r_test_done, r_led;
    logic [2:0]            r_app_cmd;
    logic [ADDR_WIDTH-1:0] r_app_addr;
    logic [DATA_WIDTH-1:0] r_app_wdf_data;
    logic [15:0]           r_error_cnt, r_pass_cnt;
    logic [c_CNT_W-1:0]    r_cmd_cnt, r_wd_cnt, r_rd_cnt;

    logic w_cmd_acc, w_wd_acc, w_cmd_fin, w_wd_fin, w_active, w_rd_phase;
    logic w_mismatch, w_cal_lost, w_pass_done, w_inv_next, w_enter_wr, w_enter_rd;
    logic w_timeout_hit;

    // Lane k of burst i is {i[23:0], k[7:0]}; odd passes use the inverse.
    function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [23:0] idx,
                                                        input logic        inv);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < c_LANES; k++) begin
            v[k*32 +: 32] = {idx, 8'(k)};
        end
        return inv ? ~v : v;
    endfunction

    assign w_cmd_acc  = r_app_en & app_rdy;
    assign w_wd_acc   = r_app_wdf_wren & app_wdf_rdy;
    // A stream is finished once it has deasserted or its last beat goes now.
    assign w_cmd_fin  = ~r_app_en | (w_cmd_acc & (r_cmd_cnt == c_LAST));
    assign w_wd_fin   = ~r_app_wdf_wren | (w_wd_acc & (r_wd_cnt == c_LAST));
    assign w_active   = (r_state == S_WRITE) | (r_state == S_READ) | (r_state == S_WAIT_RD);
    assign w_rd_phase = (r_state == S_READ) | (r_state == S_WAIT_RD);
    assign w_cal_lost = w_active & ~r_init_d;
    // Returns outside the read phase are stray and always count as errors.
    assign w_mismatch = app_rd_data_valid &
                        (~w_rd_phase |
                         (app_rd_data != f_pattern(r_rd_cnt[23:0], r_pass_cnt[0])));
    assign w_pass_done = (r_state == S_WAIT_RD) & (r_rd_cnt == c_LEN);
    // The first write beat of a new pass must already use the new polarity.
    assign w_inv_next  = r_pass_cnt[0] ^ w_pass_done;
    assign w_enter_wr  = (w_state_next == S_WRITE) & (r_state != S_WRITE);
    assign w_enter_rd  = (w_state_next == S_READ) & (r_state == S_WRITE);

`ifdef DDR_TEST_TIMEOUT_EN
    logic [31:0] r_wdog;
    logic        r_timeout;
    logic        w_activity;

    assign w_activity    = w_cmd_acc | w_wd_acc | app_rd_data_valid;
    assign w_timeout_hit = w_active & ~w_activity & (r_wdog == 32'(TIMEOUT_CYC - 1));
    assign timeout       = r_timeout;

    always_ff @(posedge clk_x1) begin
        if (!rst_n) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_active && !w_activity) begin
                r_wdog <= r_wdog + 32'd1;
            end else begin
                r_wdog <= '0;
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_x1) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (r_init_d) w_state_next = S_WRITE;
            S_WRITE:   if (w_cmd_fin && w_wd_fin) w_state_next = S_READ;
            S_READ:    if (w_cmd_acc && (r_cmd_cnt == c_LAST)) w_state_next = S_WAIT_RD;
            S_WAIT_RD: if (w_pass_done) w_state_next = (LOOP != 0) ? S_WRITE : S_DONE;
            S_DONE:    w_state_next = S_DONE;
            default:   w_state_next = S_IDLE;
        endcase
        if (w_cal_lost)    w_state_next = S_IDLE;
        if (w_timeout_hit) w_state_next = S_DONE;
    end

    always_ff @(posedge clk_x1) begin
        if (!rst_n) begin
            r_app_en       <= 1'b0;
            r_app_cmd      <= 3'b000;
            r_app_addr     <= '0;
            r_app_wdf_wren <= 1'b0;
            r_app_wdf_data <= '0;
            r_init_d       <= 1'b0;
            r_error        <= 1'b0;
            r_error_cnt    <= '0;
            r_pass_cnt     <= '0;
            r_test_done    <= 1'b0;
            r_led          <= 1'b0;
            r_cmd_cnt      <= '0;
            r_wd_cnt       <= '0;
            r_rd_cnt       <= '0;
        end else begin
            r_init_d    <= init_calib_complete;
            r_test_done <= (w_state_next == S_DONE);

            if (w_rd_phase && app_rd_data_valid) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end

            if (w_enter_wr) begin
                r_app_en       <= 1'b1;
                r_app_cmd      <= c_CMD_WR;
                r_app_addr     <= c_START;
                r_app_wdf_wren <= 1'b1;
                r_app_wdf_data <= f_pattern(24'd0, w_inv_next);
                r_cmd_cnt      <= '0;
                r_wd_cnt       <= '0;
                r_rd_cnt       <= '0;
            end else if (w_enter_rd) begin
                r_app_en       <= 1'b1;
                r_app_cmd      <= c_CMD_RD;
                r_app_addr     <= c_START;
                r_app_wdf_wren <= 1'b0;
                r_cmd_cnt      <= '0;
            end else if ((w_state_next == S_IDLE) || (w_state_next == S_DONE)) begin
                r_app_en       <= 1'b0;
                r_app_wdf_wren <= 1'b0;
            end else begin
                // Command and data streams advance independently.
                if (w_cmd_acc) begin
                    r_cmd_cnt <= r_cmd_cnt + 1'b1;
                    if (r_cmd_cnt == c_LAST) begin
                        r_app_en <= 1'b0;
                    end else begin
                        r_app_addr <= r_app_addr + c_STEP;
                    end
                end
                if (w_wd_acc) begin
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                    if (r_wd_cnt == c_LAST) begin
                        r_app_wdf_wren <= 1'b0;
                    end else begin
                        r_app_wdf_data <= f_pattern(r_wd_cnt[23:0] + 24'd1, r_pass_cnt[0]);
                    end
                end
            end

            if (w_mismatch || w_timeout_hit) begin
                r_error <= 1'b1;
                if (r_error_cnt != 16'hFFFF) begin
                    r_error_cnt <= r_error_cnt + 16'd1;
                end
            end

            if (w_pass_done) begin
                r_pass_cnt <= r_pass_cnt + 16'd1;
                if (!r_error) begin
                    r_led <= ~r_led;
                end
            end
            if (r_error) begin
                r_led <= 1'b0;
            end
        end
    end

    assign app_en                = r_app_en;
    assign app_cmd               = r_app_cmd;
    assign app_addr              = r_app_addr;
    assign app_wdf_wren          = r_app_wdf_wren;
    assign app_wdf_end           = r_app_wdf_wren;
    assign app_wdf_data          = r_app_wdf_data;
    assign init_calib_complete_d = r_init_d;
    assign error                 = r_error;
    assign error_cnt             = r_error_cnt;
    assign pass_cnt              = r_pass_cnt;
    assign test_done             = r_test_done;
    assign led                   = r_led;

endmodule
`default_nettype wire

// File: doc/ddr_test_sequencer.md
Name: ddr_test_sequencer

Overview:
- Traffic generator and checker for the DDR3 controller user (app_*) interface; runs in the memory user clock domain.
- After calibration, writes an address-derived pattern over a region, reads it back and compares in order.
- Drives error, led and calibration status toward the on-chip analyzer probe set and the board LED.
- Repeats forever or stops after one pass.

Parameters:
- ADDR_WIDTH, 29, app_addr width.
- DATA_WIDTH, 256, app data width; must be a multiple of 32.
- START_ADDR, 0, first burst address.
- ADDR_STEP, 8, address increment per burst.
- TEST_LEN, 1024, bursts per pass; 1..2^24.
- LOOP, 1, 1 = run passes continuously; 0 = stop after one pass.
- TIMEOUT_CYC, 65535, watchdog limit; used only with the optional feature.

Ports:
- clk_x1  in  1  DDR user clock.
- rst_n  in  1  synchronous, active-low reset.
- init_calib_complete  in  1  controller calibration done.
- app_rdy  in  1  command accept.
- app_wdf_rdy  in  1  write data accept.
- app_rd_data_valid  in  1  read data valid.
- app_rd_data  in  DATA_WIDTH  read data.
- app_en  out  1  command valid.
- app_cmd  out  3  3'b000 = write, 3'b001 = read.
- app_addr  out  ADDR_WIDTH  command address.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  equals app_wdf_wren (one beat per burst).
- app_wdf_data  out  DATA_WIDTH  write data.
- init_calib_complete_d  out  1  init_calib_complete registered once.
- error  out  1  sticky mismatch flag.
- error_cnt  out  16  saturating mismatch count.
- pass_cnt  out  16  completed passes; wraps.
- test_done  out  1  high in DONE.
- led  out  1  heartbeat / status.

Behaviour:
- Reset: all outputs are registered and reset to 0; FSM goes to IDLE. Reset mid-operation aborts immediately, with no handshake completion.
- Pattern: burst index i (0..TEST_LEN-1); lane k (0..DATA_WIDTH/32-1) = {i[23:0], k[7:0]}. The pattern is bitwise-inverted when pass_cnt[0] = 1.
- Address: START_ADDR + i*ADDR_STEP, truncated to ADDR_WIDTH (wraps silently).
- Handshakes: a command is accepted on app_en && app_rdy; data is accepted on app_wdf_wren && app_wdf_rdy. While stalled, app_en/app_cmd/app_addr and app_wdf_* are held stable. The command and data streams are independent, and data may lead the command.
- FSM:
  - IDLE: wait for init_calib_complete_d = 1. Then clear counters and go to WRITE. Timing: init high at cycle N → init_d high at N+1 → app_en = 1 at N+2.
  - WRITE: app_en = 1 with app_cmd = write; app_wdf_wren = 1. Separate cmd_cnt and wdata_cnt advance on their own acceptances; each stream deasserts when its count reaches TEST_LEN. When both are done, go to READ.
  - READ: app_en = 1 with app_cmd = read; cmd_cnt advances on acceptance. When cmd_cnt reaches TEST_LEN, go to WAIT_RD. Read data may return while still in READ.
  - WAIT_RD: wait until rd_cnt = TEST_LEN, then increment pass_cnt and toggle led (only if error = 0). Next state is WRITE if LOOP = 1, else DONE.
  - DONE: test_done = 1; no further commands. Leaving DONE requires reset.
- Check: each app_rd_data_valid in READ/WAIT_RD is compared with pattern(rd_cnt), then rd_cnt increments.
  - On mismatch: error = 1 from the next cycle; error_cnt increments, saturating at 16'hFFFF.
  - app_rd_data_valid in any other state counts as a mismatch and its data is ignored.
- Calibration loss: init_calib_complete_d falling outside IDLE/DONE deasserts app_en and app_wdf_wren the next cycle and returns to IDLE. error, error_cnt and pass_cnt are kept; the next pass restarts at i = 0.
- led: frozen at 0 once error = 1.

Optional Feature:
- Macro: DDR_TEST_TIMEOUT_EN.
- With the macro: a 32-bit watchdog resets on any accepted command, data beat or read return. It counts in WRITE/READ/WAIT_RD.
- On reaching TIMEOUT_CYC: error = 1, error_cnt increments, extra output timeout (1 bit, reset 0) goes sticky high, and the FSM goes to DONE.
- Without the macro: no watchdog, and the timeout port is absent.

Test Plan:
- TEST_LEN = 4, LOOP = 0, app_rdy = app_wdf_rdy = 1, memory model echoes data with 10-cycle latency:
  - 4 writes to addr 0, 8, 16, 24, then 4 reads.
  - Lane 1 of burst 2 = 32'h00000201.
  - pass_cnt = 1, test_done = 1, error = 0, led = 1.
- app_rdy low for 5 cycles during the 2nd write command: app_en/app_addr = 8 held stable; exactly 4 write commands accepted.
- Model flips bit 0 of burst 3 on readback: error = 1 one cycle after that valid; error_cnt = 1; led stays 0.
- LOOP = 1 for two passes: second-pass data is the inverse (burst 0 lane 0 = 32'hFFFFFFFF); pass_cnt = 2; no errors.
- Drop init_calib_complete mid-READ: app_en = 0 within 2 cycles; FSM in IDLE. Re-raise it: writes restart at addr 0.
- With DDR_TEST_TIMEOUT_EN and TIMEOUT_CYC = 100, model never returns read data: timeout = 1 and error = 1 after 100 idle cycles in WAIT_RD; test_done = 1.
